// File: rtl/sa_pkg.sv
// Shared types, constants and beat-generation helper for the unpool expander.
package sa_pkg;

    localparam int unsigned SA_OUTPUT_WIDTH = 14;
    localparam int unsigned LANE_WIDTH      = SA_OUTPUT_WIDTH / 2;
    localparam int unsigned FIFO_DEPTH      = 4;   // power of 2, >= 2
    localparam int unsigned WINDOW          = 4;   // 2x2 window
    localparam int unsigned IDX_WIDTH       = 4;
    localparam int unsigned PHASE_WIDTH     = $clog2(WINDOW);
    localparam int unsigned CNT_WIDTH       = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        FILL_REPLICATE = 1'b0,
        FILL_ZERO_IDX  = 1'b1
    } fill_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpool_state_e;

    typedef struct packed {
        logic [SA_OUTPUT_WIDTH-1:0] data;
        logic [IDX_WIDTH-1:0]       idx;
        logic                       out_model;
        fill_mode_e                 fill_mode;
    } unpool_entry_t;

    // Beat for window position ph: replicate, or zero everywhere except the argmax slot(s).
    function automatic logic [SA_OUTPUT_WIDTH-1:0] gen_beat(input unpool_entry_t e,
                                                             input logic [PHASE_WIDTH-1:0] ph);
        logic [SA_OUTPUT_WIDTH-1:0] beat;
        logic [LANE_WIDTH-1:0]      hi;
        logic [LANE_WIDTH-1:0]      lo;
        beat = '0;
        hi   = '0;
        lo   = '0;
        if (e.fill_mode == FILL_REPLICATE) begin
            beat = e.data;
        end else if (e.out_model) begin
            if (ph == e.idx[PHASE_WIDTH-1:0]) beat = e.data;
        end else begin
            if (ph == e.idx[2*PHASE_WIDTH-1 -: PHASE_WIDTH]) hi = e.data[SA_OUTPUT_WIDTH-1 -: LANE_WIDTH];
            if (ph == e.idx[PHASE_WIDTH-1:0])                lo = e.data[LANE_WIDTH-1:0];
            beat = {hi, lo};
        end
        return beat;
    endfunction

endpackage

// File: rtl/unpool_expander_if.sv
// Handshake/bus bundle between the unpool expander and its neighbours.
interface unpool_expander_if;
    import sa_pkg::*;

    logic                       unpool_enable;
    logic                       out_model;
    logic                       fill_mode;
    logic [SA_OUTPUT_WIDTH-1:0] in_data;
    logic [IDX_WIDTH-1:0]       in_idx;
    logic                       in_valid;
    logic                       in_ready;
    logic [SA_OUTPUT_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic [CNT_WIDTH-1:0]       fifo_count;

    // Upstream/downstream environment side
    modport master (
        output unpool_enable, out_model, fill_mode, in_data, in_idx, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, fifo_count
    );

    // Expander side
    modport slave (
        input  unpool_enable, out_model, fill_mode, in_data, in_idx, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, fifo_count
    );

endinterface

// File: rtl/unpool_fifo.sv
// Synchronous FIFO of captured pooled samples; extra pointer bit separates full from empty.
module unpool_fifo
    import sa_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  unpool_entry_t          din_i,
    output unpool_entry_t          dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    unpool_entry_t    mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign count_o = count_q;

    // Pointer and occupancy next-state; flush wins over any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end

endmodule

// File: rtl/unpool_expander.sv
// Re-expands each pooled sample into a WINDOW-beat stream (replicate or argmax zero-fill).
module unpool_expander
    import sa_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    unpool_expander_if.slave   bus
);

    unpool_state_e              state_q, state_d;
    logic [PHASE_WIDTH-1:0]     phase_q, phase_d;
    unpool_entry_t              hold_q, hold_d;
    logic [SA_OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic                       alive_q;

    unpool_entry_t              push_entry;
    unpool_entry_t              head_entry;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_flush;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       beat_accept;
    logic                       last_phase;

    // alive_q keeps in_ready low while reset is asserted.
    assign bus.in_ready = bus.unpool_enable && !fifo_full && alive_q;
    assign fifo_push    = bus.in_valid && bus.in_ready;
    assign fifo_flush   = !bus.unpool_enable;
    assign beat_accept  = out_valid_q && bus.out_ready;
    assign last_phase   = (phase_q == PHASE_WIDTH'(WINDOW - 1));

    assign push_entry = '{data:      bus.in_data,
                          idx:       bus.in_idx,
                          out_model: bus.out_model,
                          fill_mode: fill_mode_e'(bus.fill_mode)};

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    unpool_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .din_i   (push_entry),
        .dout_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (bus.fifo_count)
    );

    // Output-stage FSM; outputs are precomputed from next state so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        hold_d      = hold_q;
        fifo_pop    = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
        if (bus.unpool_enable) begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        hold_d   = head_entry;
                        phase_d  = '0;
                        state_d  = EMIT;
                    end
                end
                EMIT: begin
                    if (beat_accept) begin
                        if (last_phase) begin
                            phase_d = '0;
                            if (!fifo_empty) begin
                                // Back-to-back window, no bubble
                                fifo_pop = 1'b1;
                                hold_d   = head_entry;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            phase_d = phase_q + PHASE_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            out_valid_d = (state_d == EMIT);
            out_data_d  = out_valid_d ? gen_beat(hold_d, phase_d) : '0;
            out_last_d  = out_valid_d && (phase_d == PHASE_WIDTH'(WINDOW - 1));
        end else begin
            // Disabled: discard the window in flight and idle
            state_d = IDLE;
            phase_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            alive_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_unpool_expander.sv
// Scoreboard bench for unpool_expander: stimulus queues expected beats, a negedge monitor checks them.
module tb_unpool_expander;
    import sa_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    unpool_expander_if bus();

    unpool_expander dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [14:0] exp_q[$];   // {last, data}
    bit          t5_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference beat, written straight from the behavioural description.
    function automatic logic [13:0] model_beat(input logic [13:0] d, input logic [3:0] ix,
                                               input bit m, input bit f, input int ph);
        logic [13:0] r;
        if (!f) return d;
        if (m) return (ph == int'(ix[1:0])) ? d : 14'h0;
        r = 14'h0;
        if (ph == int'(ix[3:2])) r[13:7] = d[13:7];
        if (ph == int'(ix[1:0])) r[6:0]  = d[6:0];
        return r;
    endfunction

    task automatic exp4(input logic [13:0] b0, input logic [13:0] b1,
                        input logic [13:0] b2, input logic [13:0] b3);
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b1, b3});
    endtask

    task automatic exp_model(input logic [13:0] d, input logic [3:0] ix, input bit m, input bit f);
        for (int ph = 0; ph < 4; ph++)
            exp_q.push_back({(ph == 3), model_beat(d, ix, m, f, ph)});
    endtask

    // Offer one sample; returns #1 after the accepting edge, with the number of edges spent.
    task automatic push_sample(input logic [13:0] d, input logic [3:0] ix, input bit m, input bit f,
                               output int edges);
        bit ok;
        edges = 0;
        bus.in_data   = d;
        bus.in_idx    = ix;
        bus.out_model = m;
        bus.fill_mode = f;
        bus.in_valid  = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            edges++;
        end while (!ok && edges < 100);
        if (!ok) fail_now("push_timeout");
        bus.in_valid  = 1'b0;
        bus.out_model = ~m;   // mode changes after capture must not matter
        bus.fill_mode = ~f;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare accepted beats against the scoreboard, check stall stability and idle zeros.
    initial begin : monitor
        bit          prev_stall;
        logic [14:0] prev_beat;
        logic [14:0] e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.out_valid) begin
                    if (prev_stall)
                        check("stall_hold", 32'({bus.out_last, bus.out_data}), 32'(prev_beat));
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_beat: got 0x%0h, expected none", bus.out_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat", 32'({bus.out_last, bus.out_data}), 32'(e));
                        end
                    end
                end else begin
                    check("idle_zero", 32'({bus.out_last, bus.out_data}), 32'h0);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_beat  = {bus.out_last, bus.out_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int edges;
        int total;
        rst_n             = 1'b0;
        bus.unpool_enable = 1'b0;
        bus.out_model     = 1'b0;
        bus.fill_mode     = 1'b0;
        bus.in_data       = '0;
        bus.in_idx        = '0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        t5_done           = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid",  32'(bus.out_valid),  32'h0);
        check("rst_out_data",   32'(bus.out_data),   32'h0);
        check("rst_out_last",   32'(bus.out_last),   32'h0);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
        bus.unpool_enable = 1'b1;
        #1;
        check("rst_in_ready",   32'(bus.in_ready),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_ready_up", 32'(bus.in_ready), 32'h1);

        // T1: replicate, single value, latency
        bus.out_ready = 1'b1;
        exp4(14'h1ABC, 14'h1ABC, 14'h1ABC, 14'h1ABC);
        push_sample(14'h1ABC, 4'h0, 1'b1, 1'b0, edges);
        check("t1_valid_after_push", 32'(bus.out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("t1_valid_next_edge", 32'(bus.out_valid), 32'h1);
        check("t1_first_data",      32'(bus.out_data),  32'h1ABC);
        wait_drain("t1_drain_timeout");
        check("t1_idle_valid", 32'(bus.out_valid), 32'h0);
        check("t1_idle_data",  32'(bus.out_data),  32'h0);

        // T2: zero-fill, single value, idx 2
        exp4(14'h0, 14'h0, 14'h0123, 14'h0);
        push_sample(14'h0123, 4'b0010, 1'b1, 1'b1, edges);
        wait_drain("t2_drain_timeout");

        // T3: zero-fill, two lanes, high idx 0 / low idx 3
        exp4(14'h2A80, 14'h0, 14'h0, 14'h002A);
        push_sample({7'h55, 7'h2A}, 4'b0011, 1'b0, 1'b1, edges);
        wait_drain("t3_drain_timeout");

        // T4: fill under backpressure, then contiguous release
        bus.out_ready = 1'b0;
        total = 0;
        for (int i = 0; i < 5; i++) begin
            exp_model(14'(i * 'h0911 + 'h0101), 4'(i * 5), (i % 3) == 0, (i % 2) == 1);
            push_sample(14'(i * 'h0911 + 'h0101), 4'(i * 5), (i % 3) == 0, (i % 2) == 1, edges);
            total += edges;
        end
        check("t4_push_edges",  32'(total),          32'd5);
        check("t4_fifo_count",  32'(bus.fifo_count), 32'd4);
        check("t4_in_ready",    32'(bus.in_ready),   32'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4_contiguous", 32'(bus.out_valid), 32'h1);
        end
        wait_drain("t4_drain_timeout");

        // T5: random backpressure, per-sample modes
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    exp_model(14'(i * 'h0735 + 'h1003), 4'(i * 7 + 1), i[0], i[1]);
                    push_sample(14'(i * 'h0735 + 'h1003), 4'(i * 7 + 1), i[0], i[1], edges);
                end
                t5_done = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!(t5_done && exp_q.size() == 0) && n < 2000) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    n++;
                end
                if (n >= 2000) fail_now("t5_timeout");
            end
        join
        bus.out_ready = 1'b1;
        wait_drain("t5_drain_timeout");
        check("t5_fifo_empty", 32'(bus.fifo_count), 32'h0);

        // T6: disable mid-window with two entries queued
        bus.out_ready = 1'b0;
        exp_model(14'h0A5A, 4'h0, 1'b1, 1'b0);
        push_sample(14'h0A5A, 4'h0, 1'b1, 1'b0, edges);
        exp_model(14'h1111, 4'h1, 1'b1, 1'b0);
        push_sample(14'h1111, 4'h1, 1'b1, 1'b0, edges);
        exp_model(14'h2222, 4'h2, 1'b1, 1'b0);
        push_sample(14'h2222, 4'h2, 1'b1, 1'b0, edges);
        check("t6_queued", 32'(bus.fifo_count), 32'd2);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready     = 1'b0;
        bus.unpool_enable = 1'b0;
        #1;
        check("t6_in_ready_comb", 32'(bus.in_ready), 32'h0);
        check("t6_one_beat_taken", 32'(exp_q.size()), 32'd11);
        @(posedge clk);
        #1;
        check("t6_flush_valid", 32'(bus.out_valid),  32'h0);
        check("t6_flush_count", 32'(bus.fifo_count), 32'h0);
        check("t6_flush_ready", 32'(bus.in_ready),   32'h0);
        check("t6_flush_data",  32'(bus.out_data),   32'h0);
        exp_q.delete();
        bus.unpool_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        exp4(14'h0ABC, 14'h0, 14'h0, 14'h0);
        push_sample(14'h0ABC, 4'h0, 1'b1, 1'b1, edges);
        wait_drain("t6_drain_timeout");
        check("t6_final_count", 32'(bus.fifo_count), 32'h0);

        // T7: asynchronous reset mid-window
        exp_model(14'h3FFF, 4'h0, 1'b1, 1'b0);
        push_sample(14'h3FFF, 4'h0, 1'b1, 1'b0, edges);
        @(posedge clk);
        #1;
        check("t7_streaming", 32'(bus.out_valid), 32'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(bus.out_valid),  32'h0);
        check("t7_rst_data",  32'(bus.out_data),   32'h0);
        check("t7_rst_last",  32'(bus.out_last),   32'h0);
        check("t7_rst_ready", 32'(bus.in_ready),   32'h0);
        check("t7_rst_count", 32'(bus.fifo_count), 32'h0);
        exp_q.delete();
        #20;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t7_post_valid", 32'(bus.out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
